// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared widths, parameter defaults and FSM states for fft_stream_tx
package fft_stream_pkg;

  localparam int DATA_W          = 16;
  localparam int FRAME_LEN_DEF   = 512;
  localparam int GAP_CYCLES_DEF  = 16;
  localparam int SCALE_SHIFT_DEF = 6;
  localparam int MAX_HEIGHT_DEF  = 479;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/fft_frame_ram.sv
// rtl/fft_frame_ram.sv - simple dual-port frame buffer with one-cycle registered read
module fft_frame_ram #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk_50m,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  // Contents survive reset; only the read register is ever observed downstream.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk_50m) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_stream_tx.sv
// rtl/fft_stream_tx.sv - buffers one spectrum frame and replays it as an sop/eop framed stream
// Optional FFT_TX_SCALE_EN: samples are right-shifted and clamped on the write path.
module fft_stream_tx
  import fft_stream_pkg::*;
#(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int MAX_HEIGHT  = MAX_HEIGHT_DEF
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_sop,
  output logic              fft_eop,
  output logic              fft_valid,
  output logic [15:0]       frame_cnt
);

  localparam int                ADDR_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 1024 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
      SCALE_SHIFT < 0 || SCALE_SHIFT >= DATA_W ||
      MAX_HEIGHT < 0 || MAX_HEIGHT >= (2 ** DATA_W)) begin : g_bad_param
    $error("fft_stream_tx: parameter out of range");
  end

  tx_state_e         r_state;
  tx_state_e         w_next_state;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_done;
  logic [7:0]        r_gap_cnt;

  logic              r_s1_vld;
  logic              r_s1_sop;
  logic              r_s1_eop;

  logic              r_fft_valid;
  logic              r_fft_sop;
  logic              r_fft_eop;
  logic [DATA_W-1:0] r_fft_data;
  logic [15:0]       r_frame_cnt;

  logic              w_accept;
  logic              w_close;
  logic              w_rd_en;
  logic              w_rd_final;
  logic              w_gap_end;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_data;

`ifdef FFT_TX_SCALE_EN
  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = in_data >> SCALE_SHIFT;
  assign w_wr_data = (w_shifted > DATA_W'(MAX_HEIGHT)) ? DATA_W'(MAX_HEIGHT) : w_shifted;
`else
  assign w_wr_data = in_data;
`endif

  assign w_accept  = in_valid && in_ready;
  // A frame ends on in_last or when the buffer is full, whichever comes first.
  assign w_close   = w_accept && (in_last || (r_wr_addr == LAST_ADDR));
  assign w_gap_end = (r_gap_cnt == GAP_LAST);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_close) begin
          w_next_state = ST_SEND;
        end else if (w_accept) begin
          w_next_state = ST_FILL;
        end
      end
      // Leave SEND only once eop is actually on the port so GAP counts from it.
      ST_SEND: begin
        if (r_fft_eop) begin
          w_next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_final = 1'b0;
    if (!rst && (r_state == ST_IDLE || r_state == ST_FILL)) begin
      in_ready = 1'b1;
    end
    if (r_state == ST_SEND && !r_rd_done) begin
      w_rd_en    = 1'b1;
      w_rd_final = (r_rd_addr == r_last_addr);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_wr_addr   <= '0;
      r_last_addr <= '0;
      r_rd_addr   <= '0;
      r_rd_done   <= 1'b0;
      r_gap_cnt   <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_sop    <= 1'b0;
      r_s1_eop    <= 1'b0;
      r_fft_valid <= 1'b0;
      r_fft_sop   <= 1'b0;
      r_fft_eop   <= 1'b0;
      r_fft_data  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_wr_addr <= w_close ? '0 : r_wr_addr + 1'b1;
        if (w_close) begin
          r_last_addr <= r_wr_addr;
        end
      end

      if (w_close) begin
        r_rd_addr <= '0;
        r_rd_done <= 1'b0;
      end else if (w_rd_en) begin
        if (w_rd_final) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
      end

      // Tags travel alongside the registered RAM read, then everything lands in the output flops.
      r_s1_vld    <= w_rd_en;
      r_s1_sop    <= w_rd_en && (r_rd_addr == '0);
      r_s1_eop    <= w_rd_final;
      r_fft_valid <= r_s1_vld;
      r_fft_sop   <= r_s1_sop;
      r_fft_eop   <= r_s1_eop;
      r_fft_data  <= r_s1_vld ? w_rd_data : '0;

      if (r_fft_eop) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 8'd1 : 8'd0;
    end
  end

  fft_frame_ram #(
    .DEPTH  (FRAME_LEN),
    .WIDTH  (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_50m   (clk_50m),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign fft_valid = r_fft_valid;
  assign fft_sop   = r_fft_sop;
  assign fft_eop   = r_fft_eop;
  assign fft_data  = r_fft_data;
  assign frame_cnt = r_frame_cnt;

endmodule
